text_console: RTL
=================

// Module: text_console
// PURPOSE
//  Character-stream front end for the 80x25 text-mode video memory scanned by the VGA adapter.
//  Accepts bytes over a valid/ready stream and writes char/attr pairs at the cursor.
//  Handles CR, LF, BS and FF control codes, line wrap, and scroll-up by one row.
//  Drives the write-capable port of the shared 4 KB text RAM:
//   - cell (x,y) is at byte 2*(y*COLS+x); the char byte is even, the attr byte is odd.
// PARAMETERS
//  COLS       80     characters per row
//  ROWS       25     rows; COLS*ROWS*2 must be <= 4096
//  FILL_CHAR  8'h20  char code written by clear and scroll fill
// PORTS
//  clk         in   1   system clock; every register is clocked on its rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  ch_valid    in   1   ch_data/ch_attr are valid
//  ch_ready    out  1   block can accept a byte; high only in IDLE
//  ch_data     in   8   character or control code
//  ch_attr     in   8   attribute for this byte and for clear/scroll fill
//  vram_addr   out  12  text RAM byte address
//  vram_wdata  out  8   text RAM write data
//  vram_we     out  1   text RAM write strobe
//  vram_rdata  in   8   text RAM read data; valid one clk after vram_addr with vram_we=0
//  cursor_x    out  7   current column, 0..COLS-1
//  cursor_y    out  5   current row, 0..ROWS-1
//  busy        out  1   scroll or clear in progress
// BEHAVIOUR
//  Reset values
//   - state=IDLE, cursor_x=0, cursor_y=0.
//   - vram_addr=0, vram_wdata=0, vram_we=0, busy=0.
//   - ch_ready=1 from the first clk after rst_n deasserts.
//   - Reset mid-operation aborts at once; RAM contents are left partially updated.
//  Handshake
//   - Transfer = ch_valid & ch_ready in cycle N. ch_data and ch_attr are latched in cycle N.
//  Registered outputs
//   - All vram_* outputs are registered; "cycle N+k" is when the value is visible on the port.
//  Printable byte (>=8'h20)
//   - N+1: we=1, addr=2*(y*COLS+x), wdata=char.
//   - N+2: we=1, addr+1, wdata=attr.
//   - Cursor advances at the end of N+2. ch_ready returns high in N+3.
//  Cursor advance
//   - x<COLS-1: x+1.
//   - x=COLS-1: x=0 and y+1.
//   - Advance when y=ROWS-1: enter SCROLL; y stays ROWS-1.
//  Control codes
//   - Each is consumed in one cycle with no RAM access, except FF.
//   - 8'h0D (CR): x=0.
//   - 8'h0A (LF): y+1, or SCROLL if y=ROWS-1; x is unchanged.
//   - 8'h08 (BS): x-1 if x>0; at x=0 no change (no reverse wrap).
//   - 8'h0C (FF): enter CLEAR, then cursor=(0,0).
//   - Any other code <8'h20: ignored.
//  SCROLL, 2 cycles per byte, src = 2*COLS .. 2*COLS*ROWS-1 ascending
//   - SCR_RD: addr=src, we=0.
//   - SCR_WR: addr=src-2*COLS, wdata=vram_rdata, we=1.
//   - Then FILL over the last row, 2*COLS cycles, 1 byte/cycle: even bytes=FILL_CHAR, odd bytes=latched attr.
//   - Default totals: 7680+160 = 7840 cycles.
//  CLEAR
//   - Bytes 0..2*COLS*ROWS-1, 1 per cycle, same even/odd fill rule: 4000 cycles by default.
//  busy and ch_ready
//   - busy=1 throughout SCROLL/FILL/CLEAR.
//   - ch_ready=0 from N+1 until the cycle after the last RAM write.
//  States
//   - IDLE, WR_CHAR, WR_ATTR, SCR_RD, SCR_WR, FILL, CLEAR.
//   - Addresses use 12-bit arithmetic; no address ever reaches 2*COLS*ROWS.
// CONFIGURATION
//  CONSOLE_TAB_EN
//   - Defined: 8'h09 (HT) sets x=(x|7)+1 in one cycle with no RAM write.
//   - If that result >=COLS: x=0 and the line advances as above, including SCROLL at the last row.
//   - Undefined: 8'h09 is ignored like the other control codes.
// TESTING
//  1. Reset, send 'A' with attr 8'h1F:
//     -> writes 0x41@0x000, then 0x1F@0x001 on consecutive cycles; cursor=(1,0); ready after 3 cycles.
//  2. Cursor at (79,3), send 'Z':
//     -> writes @0x27E/0x27F; cursor=(0,4).
//  3. Fill row 24 col 79 then send 'Q':
//     -> SCROLL: byte 0x0A0 is copied to 0x000 ... 0xF9F to 0xEFF;
//     -> 0xF00..0xF9F filled 0x20/attr; busy for 7840 cycles; cursor=(0,24).
//  4. Send FF with attr 8'h07:
//     -> 4000 writes alternating 0x20/0x07; cursor=(0,0); ch_ready low throughout.
//  5. Send "AB", CR, BS, BS, LF:
//     -> cursor=(0,1); no RAM writes for the control bytes.
//  6. Assert rst_n=0 mid-SCROLL:
//     -> vram_we=0 and busy=0 immediately; after release cursor=(0,0) and ch_ready=1.
//     -> With CONSOLE_TAB_EN, HT at x=3 gives x=8; at x=77 it gives (0,y+1).

Source files
------------

// File: rtl/text_console.sv
// text_console: byte-stream front end for the 80x25 text-mode video RAM.
// Printable bytes become char/attr pairs written at the cursor; CR, LF, BS and
// FF move the cursor or clear the screen; the last line scrolls up by one row
// by copying through the RAM's single read/write port.
// Optional feature macro: CONSOLE_TAB_EN (HT advances to the next 8-column stop).
module text_console #(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 25,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch_valid,
  output logic        ch_ready,
  input  logic [7:0]  ch_data,
  input  logic [7:0]  ch_attr,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [11:0] ROW_BYTES     = 12'(2 * COLS);
  localparam logic [11:0] LAST_BYTE     = 12'(2 * COLS * ROWS - 1);
  localparam logic [11:0] LAST_ROW_BASE = 12'(2 * COLS * (ROWS - 1));
  localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, WR_CHAR, WR_ATTR, SCR_RD, SCR_WR, FILL, CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [6:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [7:0]  attr_q, attr_d;
  logic        new_line;
  logic [11:0] cell_addr;

  // Char byte address of the cell under the cursor.
  assign cell_addr = 12'((32'(y_q) * COLS + 32'(x_q)) << 1);

`ifdef CONSOLE_TAB_EN
  logic [7:0] tab_x;
  // Next 8-column tab stop; may land one past the last column.
  assign tab_x = {1'b0, x_q | 7'd7} + 8'd1;
`endif

  // Next-state, next-output and cursor logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    attr_d   = attr_q;
    new_line = 1'b0;

    case (state_q)
      IDLE: begin
        if (ch_valid) begin
          attr_d = ch_attr;
          if (ch_data >= 8'h20) begin
            state_d = WR_CHAR;
            addr_d  = cell_addr;
            wdata_d = ch_data;
            we_d    = 1'b1;
          end else begin
            case (ch_data)
              8'h0D: x_d = '0;
              8'h0A: new_line = 1'b1;
              8'h08: if (x_q != '0) x_d = x_q - 7'd1;
              8'h0C: begin
                state_d = CLEAR;
                addr_d  = '0;
                wdata_d = FILL_CHAR;
                we_d    = 1'b1;
              end
`ifdef CONSOLE_TAB_EN
              8'h09: begin
                if (tab_x >= 8'(COLS)) begin
                  x_d      = '0;
                  new_line = 1'b1;
                end else begin
                  x_d = tab_x[6:0];
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end
      WR_CHAR: begin
        state_d = WR_ATTR;
        addr_d  = addr_q + 12'd1;
        wdata_d = attr_q;
        we_d    = 1'b1;
      end
      WR_ATTR: begin
        state_d = IDLE;
        if (x_q != LAST_COL) begin
          x_d = x_q + 7'd1;
        end else begin
          x_d      = '0;
          new_line = 1'b1;
        end
      end
      SCR_RD: begin
        // The RAM returns the source byte next cycle, when the write goes out.
        state_d = SCR_WR;
        addr_d  = addr_q - ROW_BYTES;
        we_d    = 1'b1;
      end
      SCR_WR: begin
        if (addr_q == LAST_BYTE - ROW_BYTES) begin
          state_d = FILL;
          addr_d  = LAST_ROW_BASE;
          wdata_d = FILL_CHAR;
          we_d    = 1'b1;
        end else begin
          state_d = SCR_RD;
          addr_d  = addr_q + ROW_BYTES + 12'd1;
        end
      end
      FILL, CLEAR: begin
        if (addr_q == LAST_BYTE) begin
          state_d = IDLE;
          if (state_q == CLEAR) begin
            x_d = '0;
            y_d = '0;
          end
        end else begin
          addr_d  = addr_q + 12'd1;
          wdata_d = addr_d[0] ? attr_q : FILL_CHAR;
          we_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line advance shared by LF, wrap and tab: past the last row, scroll instead.
    if (new_line) begin
      if (y_q == LAST_ROW) begin
        state_d = SCR_RD;
        addr_d  = ROW_BYTES;
        we_d    = 1'b0;
      end else begin
        y_d = y_q + 5'd1;
      end
    end
  end

  // State, RAM port and cursor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      attr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      x_q     <= x_d;
      y_q     <= y_d;
      attr_q  <= attr_d;
    end
  end

  // During a scroll write the RAM's read register feeds the write data directly.
  assign vram_wdata = (state_q == SCR_WR) ? vram_rdata : wdata_q;
  assign vram_addr  = addr_q;
  assign vram_we    = we_q;
  assign cursor_x   = x_q;
  assign cursor_y   = y_q;
  assign ch_ready   = (state_q == IDLE);
  assign busy       = (state_q == SCR_RD) || (state_q == SCR_WR) ||
                      (state_q == FILL)   || (state_q == CLEAR);

endmodule
